// File: rtl/vect_pkg.sv
// vect_pkg: shared definitions for the vector issue stage and the execute unit.
//   Widths:  DATA_W (4 lanes x LANE_W), IMM_W, CTRL_W, REG_AW
//   Types:   vect_op_t  - one decoded vector operation as held in the stage
//            vect_occ_e - issue-stage occupancy (EMPTY / ONE / FULL)
//   Consts:  ALU_* function codes, shared with the execute unit
package vect_pkg;

  localparam int DATA_W    = 32;
  localparam int LANE_W    = 8;
  localparam int NUM_LANES = DATA_W / LANE_W;
  localparam int IMM_W     = 8;
  localparam int CTRL_W    = 4;
  localparam int REG_AW    = 4;

  typedef struct packed {
    logic [DATA_W-1:0] operA;
    logic [DATA_W-1:0] operB;
    logic [IMM_W-1:0]  inm;
    logic              alumux;
    logic [CTRL_W-1:0] ctrlfunc;
    logic [REG_AW-1:0] rsa;
    logic [REG_AW-1:0] rsb;
    logic [REG_AW-1:0] rd;
  } vect_op_t;

  // main/skid occupancy; skid is only ever valid while main is valid
  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_FULL  = 2'd2
  } vect_occ_e;

  localparam logic [CTRL_W-1:0] ALU_ADD  = 4'h0;
  localparam logic [CTRL_W-1:0] ALU_SUB  = 4'h1;
  localparam logic [CTRL_W-1:0] ALU_AND  = 4'h2;
  localparam logic [CTRL_W-1:0] ALU_OR   = 4'h3;
  localparam logic [CTRL_W-1:0] ALU_XOR  = 4'h4;
  localparam logic [CTRL_W-1:0] ALU_SLL  = 4'h5;
  localparam logic [CTRL_W-1:0] ALU_SRL  = 4'h6;
  localparam logic [CTRL_W-1:0] ALU_MIN  = 4'h7;
  localparam logic [CTRL_W-1:0] ALU_MAX  = 4'h8;
  localparam logic [CTRL_W-1:0] ALU_PASSB = 4'h9;

endpackage

// File: rtl/vect_fwd_sel.sv
// vect_fwd_sel: combinational operand forward select.
//   operIn   - operand as currently held / received
//   rs       - source register index of that operand
//   useReg   - operand is really read from the register file (B is not when alumux=1)
//   fwdValid, fwdRd, fwdData - result bus
//   operOut  - fwdData on an index match, otherwise operIn
module vect_fwd_sel
  import vect_pkg::*;
(
  input  logic [DATA_W-1:0] operIn,
  input  logic [REG_AW-1:0] rs,
  input  logic              useReg,
  input  logic              fwdValid,
  input  logic [REG_AW-1:0] fwdRd,
  input  logic [DATA_W-1:0] fwdData,
  output logic [DATA_W-1:0] operOut
);

  assign operOut = (fwdValid && useReg && (rs == fwdRd)) ? fwdData : operIn;

endmodule

// File: rtl/vect_issue_stage.sv
// vect_issue_stage: issue register in front of the 4-lane vector execute unit.
//   Two entries: main (drives out_*) and skid. in_ready depends on registered
//   state only, so there is no combinational path from out_ready to in_ready.
//   flush drops both entries at the next edge (an out_fire that cycle still
//   counts); rst is synchronous active-high and zeroes all state.
// Ports:
//   clk, rst, flush
//   in_valid/in_ready + in_operA, in_operB, in_inm, in_alumux, in_ctrlfunc,
//     in_rsa, in_rsb, in_rd              - from decode
//   fwd_valid, fwd_rd, fwd_data          - execute/writeback result bus
//   out_valid/out_ready + out_operA, out_operB, out_inm, out_alumux,
//     out_ctrlfunc, out_rd               - to execute
// Build option: VECT_ISSUE_FWD_EN enables operand forwarding from the result
//   bus; when undefined the fwd_* ports are ignored.
module vect_issue_stage
  import vect_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_operA,
  input  logic [DATA_W-1:0] in_operB,
  input  logic [IMM_W-1:0]  in_inm,
  input  logic              in_alumux,
  input  logic [CTRL_W-1:0] in_ctrlfunc,
  input  logic [REG_AW-1:0] in_rsa,
  input  logic [REG_AW-1:0] in_rsb,
  input  logic [REG_AW-1:0] in_rd,
  input  logic              fwd_valid,
  input  logic [REG_AW-1:0] fwd_rd,
  input  logic [DATA_W-1:0] fwd_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_operA,
  output logic [DATA_W-1:0] out_operB,
  output logic [IMM_W-1:0]  out_inm,
  output logic              out_alumux,
  output logic [CTRL_W-1:0] out_ctrlfunc,
  output logic [REG_AW-1:0] out_rd
);

  localparam int NUM_ENT = 2;  // [0] = main, [1] = skid

  vect_occ_e                          occ;
  vect_op_t [NUM_ENT-1:0]             ent;
  vect_op_t [NUM_ENT-1:0]             entSrc;
  vect_op_t [NUM_ENT-1:0]             entNxt;
  logic     [NUM_ENT-1:0]             entLive;
  logic     [NUM_ENT-1:0][DATA_W-1:0] fwdOperA;
  logic     [NUM_ENT-1:0][DATA_W-1:0] fwdOperB;
  vect_op_t                           inOp;
  logic mainVld, skidVld, inFire, outFire, loadMain, loadSkid, fwdOn;

  assign mainVld  = (occ != OCC_EMPTY);
  assign skidVld  = (occ == OCC_FULL);
  assign in_ready = ~skidVld & ~rst;
  assign inFire   = in_valid & in_ready;
  assign outFire  = mainVld & out_ready;

`ifdef VECT_ISSUE_FWD_EN
  assign fwdOn = fwd_valid;
`else
  // forwarding compiled out: the select instances collapse to pass-through
  logic unusedFwd;
  assign fwdOn     = 1'b0;
  assign unusedFwd = fwd_valid;
`endif

  always_comb begin
    inOp          = '0;
    inOp.operA    = in_operA;
    inOp.operB    = in_operB;
    inOp.inm      = in_inm;
    inOp.alumux   = in_alumux;
    inOp.ctrlfunc = in_ctrlfunc;
    inOp.rsa      = in_rsa;
    inOp.rsb      = in_rsb;
    inOp.rd       = in_rd;

    // main refills when it is free or leaving; skid has priority to keep order
    loadMain   = (~mainVld | outFire) & (skidVld | inFire);
    entSrc[0]  = loadMain ? (skidVld ? ent[1] : inOp) : ent[0];
    entLive[0] = loadMain | mainVld;

    // skid only catches a new op when main is stalled
    loadSkid   = mainVld & ~skidVld & inFire & ~outFire;
    entSrc[1]  = loadSkid ? inOp : ent[1];
    entLive[1] = loadSkid | skidVld;
  end

  // Forwarding is applied after the source mux, so capture, hold and the
  // skid->main move all see the same-cycle result bus. Dead entries are not
  // touched so idle outputs stay put.
  for (genvar e = 0; e < NUM_ENT; e++) begin : gEnt
    vect_fwd_sel uSelA (
      .operIn  (entSrc[e].operA),
      .rs      (entSrc[e].rsa),
      .useReg  (1'b1),
      .fwdValid(fwdOn & entLive[e]),
      .fwdRd   (fwd_rd),
      .fwdData (fwd_data),
      .operOut (fwdOperA[e])
    );
    vect_fwd_sel uSelB (
      .operIn  (entSrc[e].operB),
      .rs      (entSrc[e].rsb),
      .useReg  (~entSrc[e].alumux),
      .fwdValid(fwdOn & entLive[e]),
      .fwdRd   (fwd_rd),
      .fwdData (fwd_data),
      .operOut (fwdOperB[e])
    );
  end

  always_comb begin
    entNxt = entSrc;
    for (int e = 0; e < NUM_ENT; e++) begin
      entNxt[e].operA = fwdOperA[e];
      entNxt[e].operB = fwdOperB[e];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      occ <= OCC_EMPTY;
      ent <= '0;
    end else begin
      ent <= entNxt;
      if (flush) begin
        occ <= OCC_EMPTY;
      end else begin
        case (occ)
          OCC_EMPTY: if (inFire) occ <= OCC_ONE;
          OCC_ONE: begin
            if (inFire && !outFire)      occ <= OCC_FULL;
            else if (!inFire && outFire) occ <= OCC_EMPTY;
          end
          OCC_FULL:  if (outFire) occ <= OCC_ONE;
          default:   occ <= OCC_EMPTY;
        endcase
      end
    end
  end

  assign out_valid    = mainVld;
  assign out_operA    = ent[0].operA;
  assign out_operB    = ent[0].operB;
  assign out_inm      = ent[0].inm;
  assign out_alumux   = ent[0].alumux;
  assign out_ctrlfunc = ent[0].ctrlfunc;
  assign out_rd       = ent[0].rd;

endmodule

// File: tb/tb_vect_issue_stage.sv
// Bench for vect_issue_stage: directed cases with literal expectations, then
// randomized traffic checked every cycle against a queue model (max depth 2).
module tb_vect_issue_stage;
  import vect_pkg::*;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              flush = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [DATA_W-1:0] in_operA = '0;
  logic [DATA_W-1:0] in_operB = '0;
  logic [IMM_W-1:0]  in_inm = '0;
  logic              in_alumux = 1'b0;
  logic [CTRL_W-1:0] in_ctrlfunc = '0;
  logic [REG_AW-1:0] in_rsa = '0;
  logic [REG_AW-1:0] in_rsb = '0;
  logic [REG_AW-1:0] in_rd = '0;
  logic              fwd_valid = 1'b0;
  logic [REG_AW-1:0] fwd_rd = '0;
  logic [DATA_W-1:0] fwd_data = '0;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [DATA_W-1:0] out_operA;
  logic [DATA_W-1:0] out_operB;
  logic [IMM_W-1:0]  out_inm;
  logic              out_alumux;
  logic [CTRL_W-1:0] out_ctrlfunc;
  logic [REG_AW-1:0] out_rd;

  vect_issue_stage dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_operA(in_operA), .in_operB(in_operB), .in_inm(in_inm),
    .in_alumux(in_alumux), .in_ctrlfunc(in_ctrlfunc),
    .in_rsa(in_rsa), .in_rsb(in_rsb), .in_rd(in_rd),
    .fwd_valid(fwd_valid), .fwd_rd(fwd_rd), .fwd_data(fwd_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_operA(out_operA), .out_operB(out_operB), .out_inm(out_inm),
    .out_alumux(out_alumux), .out_ctrlfunc(out_ctrlfunc), .out_rd(out_rd)
  );

  always #5 clk = ~clk;

  int nChecks = 0;
  int nErrs   = 0;
  bit chkEn   = 1'b0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    nChecks++;
    if (act !== exp) begin
      nErrs++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // ---------------- reference model: an in-order queue of at most 2 ops ----
  vect_op_t q[$];

  function automatic vect_op_t fwdApply(input vect_op_t op);
    vect_op_t r = op;
`ifdef VECT_ISSUE_FWD_EN
    if (fwd_valid && op.rsa == fwd_rd) r.operA = fwd_data;
    if (fwd_valid && !op.alumux && op.rsb == fwd_rd) r.operB = fwd_data;
`endif
    return r;
  endfunction

  function automatic vect_op_t curIn();
    vect_op_t r;
    r.operA = in_operA; r.operB = in_operB; r.inm = in_inm;
    r.alumux = in_alumux; r.ctrlfunc = in_ctrlfunc;
    r.rsa = in_rsa; r.rsb = in_rsb; r.rd = in_rd;
    return r;
  endfunction

  bit mOut, mIn;
  always @(posedge clk) begin
    if (rst) begin
      q.delete();
    end else begin
      mOut = (q.size() > 0) && out_ready;
      mIn  = in_valid && (q.size() < 2);
      foreach (q[i]) q[i] = fwdApply(q[i]);
      if (mOut) void'(q.pop_front());
      if (flush) q.delete();
      else if (mIn) q.push_back(fwdApply(curIn()));
    end
  end

  // every-cycle comparison against the model
  always @(negedge clk) begin
    if (chkEn) begin
      check("out_valid", out_valid, q.size() > 0);
      check("in_ready", in_ready, !rst && q.size() < 2);
      if (q.size() > 0)
        check("out_fields",
              {out_operA, out_operB, out_inm, out_alumux, out_ctrlfunc, out_rd},
              {q[0].operA, q[0].operB, q[0].inm, q[0].alumux, q[0].ctrlfunc, q[0].rd});
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic drive(input logic v, input logic [31:0] a, input logic [31:0] b,
                       input logic mux, input logic [3:0] fn, input logic [3:0] rsa,
                       input logic [3:0] rsb, input logic [3:0] rd);
    in_valid = v; in_operA = a; in_operB = b; in_inm = a[7:0] ^ b[7:0];
    in_alumux = mux; in_ctrlfunc = fn; in_rsa = rsa; in_rsb = rsb; in_rd = rd;
  endtask

  logic [31:0] expA, expB;

  initial begin
    // reset state
    rst = 1'b1;
    step(); step();
    chkEn = 1'b1;
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_in_ready", in_ready, 1'b0);
    check("rst_fields", {out_operA, out_operB, out_inm, out_alumux, out_ctrlfunc, out_rd}, '0);
    rst = 1'b0;
    #1;
    check("post_rst_in_ready", in_ready, 1'b1);

    // single op, one-cycle latency
    out_ready = 1'b1;
    drive(1, 32'h01020304, 32'h10203040, 0, ALU_ADD, 1, 2, 3);
    step();
    check("single_valid", out_valid, 1'b1);
    check("single_operA", out_operA, 32'h01020304);
    check("single_operB", out_operB, 32'h10203040);
    check("single_inm", out_inm, 8'h44);
    check("single_rd", out_rd, 4'd3);
    check("single_in_ready", in_ready, 1'b1);
    in_valid = 1'b0;
    step();
    check("single_drain", out_valid, 1'b0);

    // back-pressure: A main, B skid, C refused, then in-order drain
    out_ready = 1'b0;
    drive(1, 32'hAAAA0001, 32'h0, 1, ALU_SUB, 1, 1, 4);
    step();
    drive(1, 32'hBBBB0002, 32'h0, 1, ALU_AND, 1, 1, 5);
    step();
    check("bp_full_in_ready", in_ready, 1'b0);
    drive(1, 32'hCCCC0003, 32'h0, 1, ALU_OR, 1, 1, 6);
    step();
    check("bp_hold_A", out_operA, 32'hAAAA0001);
    check("bp_hold_in_ready", in_ready, 1'b0);
    out_ready = 1'b1;
    step();
    check("bp_B", out_operA, 32'hBBBB0002);
    step();
    check("bp_C", out_operA, 32'hCCCC0003);
    check("bp_C_rd", out_rd, 4'd6);
    in_valid = 1'b0;
    step();
    check("bp_empty", out_valid, 1'b0);

    // flush with both entries full and a new op offered
    out_ready = 1'b0;
    drive(1, 32'hD0D0D0D0, 32'h0, 0, ALU_XOR, 8, 9, 1);
    step();
    drive(1, 32'hE0E0E0E0, 32'h0, 0, ALU_XOR, 8, 9, 2);
    step();
    drive(1, 32'hF0F0F0F0, 32'h0, 0, ALU_XOR, 8, 9, 3);
    flush = 1'b1;
    step();
    flush = 1'b0; in_valid = 1'b0;
    check("flush_valid", out_valid, 1'b0);
    check("flush_in_ready", in_ready, 1'b1);
    step();
    check("flush_dropped", out_valid, 1'b0);

    // held-entry forwarding on operA
    drive(1, 32'h11111111, 32'h33333333, 0, ALU_ADD, 5, 6, 7);
    step();
    in_valid = 1'b0;
    fwd_valid = 1'b1; fwd_rd = 4'd5; fwd_data = 32'hDEADBEEF;
    step();
`ifdef VECT_ISSUE_FWD_EN
    expA = 32'hDEADBEEF;
`else
    expA = 32'h11111111;
`endif
    check("fwd_held_operA", out_operA, expA);
    check("fwd_held_operB", out_operB, 32'h33333333);
    fwd_valid = 1'b0; out_ready = 1'b1;
    step();
    out_ready = 1'b0;

    // alumux=1: operB ignores a matching rsb
    drive(1, 32'h44444444, 32'h22222222, 1, ALU_SLL, 2, 5, 8);
    step();
    in_valid = 1'b0;
    fwd_valid = 1'b1; fwd_rd = 4'd5; fwd_data = 32'hDEADBEEF;
    step();
    check("fwd_mux_operB", out_operB, 32'h22222222);
    check("fwd_mux_operA", out_operA, 32'h44444444);
    fwd_valid = 1'b0; out_ready = 1'b1;
    step();

    // capture-cycle forward, rsa == rsb
    drive(1, 32'hAAAAAAAA, 32'hBBBBBBBB, 0, ALU_MAX, 7, 7, 9);
    fwd_valid = 1'b1; fwd_rd = 4'd7; fwd_data = 32'hCAFEF00D;
    step();
`ifdef VECT_ISSUE_FWD_EN
    expA = 32'hCAFEF00D; expB = 32'hCAFEF00D;
`else
    expA = 32'hAAAAAAAA; expB = 32'hBBBBBBBB;
`endif
    check("cap_operA", out_operA, expA);
    check("cap_operB", out_operB, expB);
    in_valid = 1'b0; fwd_valid = 1'b0;
    step();

    // reset with FULL occupancy
    out_ready = 1'b0;
    drive(1, 32'h12345678, 32'h9ABCDEF0, 0, ALU_MIN, 3, 4, 10);
    step();
    drive(1, 32'h87654321, 32'h0FEDCBA9, 0, ALU_MIN, 3, 4, 11);
    step();
    rst = 1'b1; out_ready = 1'b1;
    step();
    check("midrst_valid", out_valid, 1'b0);
    check("midrst_fields", {out_operA, out_operB, out_inm, out_alumux, out_ctrlfunc, out_rd}, '0);
    check("midrst_in_ready", in_ready, 1'b0);
    rst = 1'b0; in_valid = 1'b0;
    #1;
    check("midrst_release", in_ready, 1'b1);
    step();

    // randomized traffic; rsa/rsb/fwd_rd kept in a small range to force hits
    for (int i = 0; i < 3000; i++) begin
      drive($urandom_range(0, 3) != 0, $urandom, $urandom, 1'($urandom_range(0, 1)),
            4'($urandom_range(0, 15)), 4'($urandom_range(0, 3)), 4'($urandom_range(0, 3)),
            4'($urandom_range(0, 15)));
      out_ready = $urandom_range(0, 2) != 0;
      flush     = $urandom_range(0, 24) == 0;
      rst       = $urandom_range(0, 99) == 0;
      fwd_valid = $urandom_range(0, 1) == 1;
      fwd_rd    = 4'($urandom_range(0, 3));
      fwd_data  = $urandom;
      step();
    end

    $display("CHECKS %0d ERRORS %0d", nChecks, nErrs);
    $finish;
  end

endmodule

// File: doc/vect_issue_stage.md
Name: vect_issue_stage

Overview:
- Pipeline stage directly upstream of the vector execute unit (four 8-bit lane ALUs).
- Registers decoded vector operations and presents operA, operB, Inm, aluMux and CtrlFunc to the execute unit.
- Uses a valid/ready handshake with a 2-entry skid buffer, synchronous flush, and operand forwarding from the execute/writeback result bus.
- Sits between vector decode (register-file read) and the vector execute unit.

Parameters:
DATA_W, 32, operand width (4 lanes x 8 bits)
IMM_W, 8, immediate width, broadcast to all lanes downstream
CTRL_W, 4, ALU function code width
REG_AW, 4, vector register index width

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  reset, synchronous, active-high
flush  in  1  discard all held operations at next edge
in_valid  in  1  decode presents an operation
in_ready  out  1  stage can accept an operation this cycle
in_operA  in  DATA_W  register-file value of source A
in_operB  in  DATA_W  register-file value of source B
in_inm  in  IMM_W  immediate
in_alumux  in  1  1 = lanes use immediate, 0 = operB
in_ctrlfunc  in  CTRL_W  ALU function
in_rsa  in  REG_AW  source A register index
in_rsb  in  REG_AW  source B register index
in_rd  in  REG_AW  destination register index
fwd_valid  in  1  result bus carries a register write this cycle
fwd_rd  in  REG_AW  result bus destination index
fwd_data  in  DATA_W  result bus value
out_valid  out  1  operation presented to execute
out_ready  in  1  execute accepts the operation
out_operA  out  DATA_W  to execute operA
out_operB  out  DATA_W  to execute operB
out_inm  out  IMM_W  to execute Inm
out_alumux  out  1  to execute aluMux
out_ctrlfunc  out  CTRL_W  to execute CtrlFunc
out_rd  out  REG_AW  destination, carried to writeback

Behaviour:
- Entries: main (drives out_*) and skid. Each entry holds the full operation plus rsa/rsb and a valid bit.
- in_fire = in_valid & in_ready. out_fire = out_valid & out_ready.
- in_ready = ~skid_valid & ~rst. It is a function of registered state only, with no combinational path from out_ready.
- out_valid = main_valid.
- Occupancy states and transitions:
  - EMPTY (main 0, skid 0): in_fire -> ONE.
  - ONE (main 1, skid 0):
    - in_fire & out_fire -> ONE, main replaced by the new operation.
    - in_fire & ~out_ready -> FULL, new operation goes to skid.
    - out_fire only -> EMPTY.
  - FULL (main 1, skid 1): in_ready = 0. out_fire -> ONE, skid moves to main. No other transition.
- Latency: in_fire at edge N gives out_valid at N+1 (EMPTY case). Throughput is 1 operation/cycle. Order is strictly preserved.
- Held outputs are stable while out_valid & ~out_ready, except for forwarding updates.
- Flush:
  - At the next edge, main_valid = skid_valid = 0.
  - Flush overrides an in_fire in the same cycle; the new operation is dropped.
  - An out_fire in the flush cycle still completes, because execute samples it.
- Reset:
  - All valids = 0, all data fields = 0, so out_* = 0 and out_valid = 0.
  - in_ready = 0 while rst is high and 1 on the first cycle after rst deasserts.
  - rst mid-operation drops all entries with no output.
- Forwarding (when enabled), evaluated per cycle:
  - Capture: if fwd_valid & fwd_rd == in_rsa, store fwd_data as operA. Same rule for operB/in_rsb, applied only when in_alumux = 0.
  - Held entries: each cycle, any valid entry whose rsa (or rsb with alumux = 0) matches fwd_rd has that operand overwritten with fwd_data.
  - The skid->main move applies the same-cycle update.
  - rsa == rsb: both operands are updated.
  - Register index 0 has no special treatment.
- Width rules: no arithmetic in this stage; fields are passed bit-exact.

Optional Feature:
- VECT_ISSUE_FWD_EN defined: forwarding as specified above.
- VECT_ISSUE_FWD_EN undefined: fwd_* ports remain but are ignored, operands are stored exactly as received, and the rsa/rsb storage may be optimized away.

Decomposition:
- Package vect_pkg holds:
  - DATA_W, LANE_W = 8, IMM_W, CTRL_W, REG_AW.
  - A packed typedef vect_op_t {operA, operB, inm, alumux, ctrlfunc, rsa, rsb, rd}.
  - ALU function code constants shared with the execute unit.
- One sub-module, vect_fwd_sel: combinational operand select, taking (operand, rs, use_reg, fwd_valid, fwd_rd, fwd_data) and returning the operand. It is instantiated four times: capture A/B, held A/B per entry, merged via the entry loop.

Test Plan:
- Reset then single op (operA=0x01020304, operB=0x10203040, ctrlfunc=0, rd=3), out_ready=1 -> out_valid=1 one cycle later with identical fields; in_ready=1 throughout.
- out_ready=0, push 3 ops A, B, C -> A on out_*, B in skid, in_ready=0 and C not accepted; raise out_ready -> A, B, C delivered in order on consecutive cycles.
- Flush with main and skid full plus in_valid=1 -> next cycle out_valid=0, in_ready=1; dropped op never appears.
- VECT_ISSUE_FWD_EN: op with rsa=5 held with out_ready=0; fwd_valid=1, fwd_rd=5, fwd_data=0xDEADBEEF -> out_operA=0xDEADBEEF next cycle; same with alumux=1 and rsb=5 -> out_operB unchanged.
- Capture-cycle forward with rsa=rsb=7 and fwd_rd=7 -> both operands equal fwd_data; without the macro both equal the register-file values.
- Assert rst mid-stream with FULL occupancy -> next cycle all out_* = 0, out_valid=0; in_ready=0 while rst is high and 1 after.
